// File: rtl/upper_pc_table_pkg.sv
// Shared sizing and types for the upper-PC compression table that sits beside the BTB.
// The victim function decodes the 3-bit tree PLRU state {b2, b1, b0}.
package upper_pc_table_pkg;

   localparam int UPPER_PC_TABLE_ENTRIES     = 4;
   localparam int UPPER_PC_WIDTH             = 18;
   localparam int LOG_UPPER_PC_TABLE_ENTRIES = $clog2(UPPER_PC_TABLE_ENTRIES);

   typedef logic [UPPER_PC_WIDTH-1:0]             upper_pc_t;
   typedef logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] upc_index_t;
   typedef logic [2:0]                            plru_state_t;

   // Bit 0 is the root and picks a pair; bits 1 and 2 pick within pair 0/1 and pair 2/3.
   function automatic upc_index_t plru_victim(input plru_state_t state);
      if (!state[0]) return state[1] ? upc_index_t'(1) : upc_index_t'(0);
      else           return state[2] ? upc_index_t'(3) : upc_index_t'(2);
   endfunction

endpackage

// File: rtl/upper_pc_table_plru.sv
// 4-way tree pseudo-LRU: holds the tree bits, advances them on a touch and
// presents the current victim combinationally.
module upper_pc_plru
   import upper_pc_table_pkg::*;
(
   input  logic       CLK,
   input  logic       nRST,
   input  logic       touch_valid,
   input  upc_index_t touch_index,
   output upc_index_t victim_index
);

   plru_state_t plru_reg;
   plru_state_t plru_next;

   always_comb begin
      plru_next = plru_reg;
      if (touch_valid) begin
         if (touch_index < upc_index_t'(2)) begin
            plru_next[0] = 1'b1;
            plru_next[1] = (touch_index == upc_index_t'(0));
         end else begin
            plru_next[0] = 1'b0;
            plru_next[2] = (touch_index == upc_index_t'(2));
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) plru_reg <= 3'b000;
      else       plru_reg <= plru_next;
   end

   assign victim_index = plru_victim(plru_reg);

endmodule

// File: rtl/upper_pc_table.sv
// Maps full upper PCs to small table indices (update port) and back (read port),
// letting BTB/RAS entries store only a short index for the high target bits.
module upper_pc_table
   import upper_pc_table_pkg::*;
(
   input  logic       CLK,
   input  logic       nRST,
   input  logic       read_valid_in,
   input  upc_index_t read_index_in,
   output upper_pc_t  read_upper_PC_out,
   input  logic       update0_valid_in,
   input  upper_pc_t  update0_upper_PC_in,
   output upc_index_t update1_index_out
);

   upper_pc_t                         array_reg [UPPER_PC_TABLE_ENTRIES];
   logic [UPPER_PC_TABLE_ENTRIES-1:0] valid_reg;
   logic [UPPER_PC_TABLE_ENTRIES-1:0] hit_vec;

   logic       hit_found;
   upc_index_t hit_index;
   logic       free_found;
   upc_index_t free_index;
   upc_index_t victim_index;
   upc_index_t alloc_index;
   upc_index_t update_index;
   logic       touch_valid;
   upc_index_t touch_index;

   generate
      for (genvar gi = 0; gi < UPPER_PC_TABLE_ENTRIES; gi++) begin : g_cam
         assign hit_vec[gi] = valid_reg[gi] && (array_reg[gi] == update0_upper_PC_in);
      end
   endgenerate

   // Descending scan so the lowest-index invalid entry is the one left selected.
   always_comb begin
      hit_found  = 1'b0;
      hit_index  = '0;
      free_found = 1'b0;
      free_index = '0;
      for (int i = UPPER_PC_TABLE_ENTRIES - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit_found = 1'b1;
            hit_index = upc_index_t'(i);
         end
         if (!valid_reg[i]) begin
            free_found = 1'b1;
            free_index = upc_index_t'(i);
         end
      end
   end

   assign alloc_index  = free_found ? free_index : victim_index;
   assign update_index = hit_found ? hit_index : alloc_index;

   // An update owns the PLRU touch; a read only touches when no update is present.
   assign touch_valid = update0_valid_in || read_valid_in;
   assign touch_index = update0_valid_in ? update_index : read_index_in;

   upper_pc_plru u_plru (
      .CLK          (CLK),
      .nRST         (nRST),
      .touch_valid  (touch_valid),
      .touch_index  (touch_index),
      .victim_index (victim_index)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < UPPER_PC_TABLE_ENTRIES; i++) array_reg[i] <= '0;
         valid_reg <= '0;
      end else if (update0_valid_in && !hit_found) begin
         array_reg[alloc_index] <= update0_upper_PC_in;
         valid_reg[alloc_index] <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         read_upper_PC_out <= '0;
         update1_index_out <= '0;
      end else begin
         if (read_valid_in)    read_upper_PC_out <= array_reg[read_index_in];
         if (update0_valid_in) update1_index_out <= update_index;
      end
   end

endmodule

// File: tb/tb_upper_pc_table.sv
// Self-checking bench for upper_pc_table: directed scenarios plus random traffic
// compared against a table-level reference model.
module tb_upper_pc_table;
   import upper_pc_table_pkg::*;

   logic       CLK;
   logic       nRST;
   logic       read_valid_in;
   upc_index_t read_index_in;
   upper_pc_t  read_upper_PC_out;
   logic       update0_valid_in;
   upper_pc_t  update0_upper_PC_in;
   upc_index_t update1_index_out;

   int checks_total;
   int errors_total;

   // reference model state
   logic [17:0] m_pc    [4];
   bit          m_valid [4];
   bit          m_root, m_left, m_right;
   logic [17:0] m_read;
   logic [1:0]  m_idx;

   upper_pc_table dut (
      .CLK                 (CLK),
      .nRST                (nRST),
      .read_valid_in       (read_valid_in),
      .read_index_in       (read_index_in),
      .read_upper_PC_out   (read_upper_PC_out),
      .update0_valid_in    (update0_valid_in),
      .update0_upper_PC_in (update0_upper_PC_in),
      .update1_index_out   (update1_index_out)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got !== exp) begin
         errors_total++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_pc[i]    = '0;
         m_valid[i] = 0;
      end
      m_root = 0; m_left = 0; m_right = 0;
      m_read = '0;
      m_idx  = '0;
   endfunction

   function automatic int model_victim();
      if (!m_root) return m_left ? 1 : 0;
      return m_right ? 3 : 2;
   endfunction

   function automatic void model_touch(input int i);
      if (i < 2) begin m_root = 1; m_left  = (i == 0); end
      else       begin m_root = 0; m_right = (i == 2); end
   endfunction

   function automatic void model_apply(input bit rv, input int ri, input bit uv, input logic [17:0] upc);
      int idx;
      int free;
      if (rv) m_read = m_pc[ri];
      if (uv) begin
         idx = -1;
         for (int i = 0; i < 4; i++) if (m_valid[i] && m_pc[i] == upc) idx = i;
         if (idx < 0) begin
            free = -1;
            for (int i = 3; i >= 0; i--) if (!m_valid[i]) free = i;
            idx = (free >= 0) ? free : model_victim();
            m_pc[idx]    = upc;
            m_valid[idx] = 1;
         end
         m_idx = idx[1:0];
         model_touch(idx);
      end else if (rv) begin
         model_touch(ri);
      end
   endfunction

   // Drives one cycle of requests, advances the model, and checks both outputs.
   task automatic step(input bit rv, input int ri, input bit uv, input logic [17:0] upc);
      read_valid_in       = rv;
      read_index_in       = ri[1:0];
      update0_valid_in    = uv;
      update0_upper_PC_in = upc;
      @(posedge CLK);
      model_apply(rv, ri, uv, upc);
      #1;
      check_val("read_pc", read_upper_PC_out, m_read);
      check_val("upd_idx", update1_index_out, m_idx);
      $display("cyc rv=%0d ri=%0d uv=%0d upc=0x%05h -> read=0x%05h idx=%0d", rv, ri, uv, upc,
               read_upper_PC_out, update1_index_out);
      read_valid_in    = 0;
      update0_valid_in = 0;
   endtask

   task automatic do_reset();
      read_valid_in = 0; read_index_in = '0;
      update0_valid_in = 0; update0_upper_PC_in = '0;
      nRST = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1;
      model_reset();
   endtask

   initial begin
      checks_total = 0;
      errors_total = 0;
      model_reset();
      do_reset();

      // reset state and read of an untouched entry
      #1;
      check_val("rst_read", read_upper_PC_out, 0);
      check_val("rst_idx", update1_index_out, 0);
      step(1, 2, 0, '0);
      check_val("t1_read", read_upper_PC_out, 0);

      // fill in invalid-first order
      step(0, 0, 1, 18'h00001); check_val("t2_i0", update1_index_out, 0);
      step(0, 0, 1, 18'h00002); check_val("t2_i1", update1_index_out, 1);
      step(0, 0, 1, 18'h00003); check_val("t2_i2", update1_index_out, 2);
      step(0, 0, 1, 18'h00004); check_val("t2_i3", update1_index_out, 3);

      // eviction sequence driven by the tree PLRU
      step(0, 0, 1, 18'h0000E); check_val("t4_evict", update1_index_out, 0);
      step(0, 0, 1, 18'h00002); check_val("t4_hit", update1_index_out, 1);
      step(0, 0, 1, 18'h0000F); check_val("t4_evict2", update1_index_out, 2);
      step(1, 2, 0, '0);        check_val("t4_read", read_upper_PC_out, 18'h0000F);

      // same-cycle read and allocating update of entry 0: old value returned
      step(1, 0, 1, 18'h12345);
      check_val("t5_idx", update1_index_out, 0);
      check_val("t5_old", read_upper_PC_out, 18'h0000E);
      step(1, 0, 0, '0);        check_val("t5_new", read_upper_PC_out, 18'h12345);

      // repeated hits leave the table unchanged
      do_reset();
      for (int k = 1; k <= 4; k++) step(0, 0, 1, 18'(k));
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 1, 18'h00003);
         check_val("t3_hit", update1_index_out, 2);
      end
      for (int k = 0; k < 4; k++) begin
         step(1, k, 0, '0);
         check_val("t3_entry", read_upper_PC_out, 32'(k + 1));
      end

      // reset asserted between a request and its response
      read_valid_in = 1; read_index_in = 2'd3;
      update0_valid_in = 1; update0_upper_PC_in = 18'h00077;
      #2 nRST = 0;
      @(posedge CLK); #1;
      check_val("t6_read", read_upper_PC_out, 0);
      check_val("t6_idx", update1_index_out, 0);
      read_valid_in = 0; update0_valid_in = 0;
      @(negedge CLK);
      nRST = 1;
      model_reset();
      step(0, 0, 1, 18'h00001); check_val("t6_alloc0", update1_index_out, 0);
      step(0, 0, 1, 18'h00009); check_val("t6_alloc1", update1_index_out, 1);
      step(1, 3, 0, '0);        check_val("t6_empty", read_upper_PC_out, 0);

      // random traffic against the model; a small PC pool forces hits and evictions
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [17:0] upc;
         upc = ($urandom_range(0, 9) == 0) ? 18'($urandom) : 18'($urandom_range(1, 7));
         step($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
              $urandom_range(0, 3) != 0, upc);
      end

      $display("Result: errors=%0d of %0d checks", errors_total, checks_total);
      $finish;
   end

endmodule
